cpu_axi_bridge: RTL
===================

Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the CPU core.
- Converts the core's two SRAM-like request/response ports (instruction fetch and data access) into one AXI3 master.
- Supports at most one outstanding read and at most one outstanding write.
- Constant AXI fields are tied off by the SoC wrapper: id=0, len=0, burst=INCR, lock/cache/prot=0, rlast/rresp/bresp ignored.

Parameters:
- (none); address and data paths are fixed at 32 bits.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
inst_req  in  1  fetch request (always word-sized read)
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data valid on rsp_rdata (1-cycle pulse)
data_req  in  1  data request
data_wr  in  1  1=store, 0=load
data_size  in  2  0=byte, 1=half, 2=word
data_wstrb  in  4  store byte enables
data_addr  in  32  data address
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  load data valid or store completed (1-cycle pulse)
rsp_rdata  out  32  read data shared by both ports; qualified by the *_data_ok pulses
araddr  out  32  AXI read address
arsize  out  3  {1'b0, size}
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  R data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  AXI write address
awsize  out  3  {1'b0, data_size}
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  W data
wstrb  out  4  W strobes
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- **Reset (asynchronous):**
  - Read FSM goes to R_IDLE, write FSM to W_IDLE.
  - All valid/ready outputs and both *_data_ok outputs drop to 0; rsp_rdata is 0.
  - All address/data/size/strobe registers are 0.
- **Read FSM R_IDLE -> R_AR -> R_R -> R_IDLE:**
  - Leaves R_IDLE on an accepted read.
  - R_AR holds arvalid=1 with stable araddr/arsize until arvalid&arready.
  - R_R holds rready=1 until rvalid&rready, then returns to R_IDLE.
- **Write FSM W_IDLE -> W_AW -> W_B -> W_IDLE:**
  - W_AW drives awvalid and wvalid together. Each drops independently on its own handshake, tracked by aw_done/w_done.
  - W_AW moves to W_B when both handshakes are done (same cycle allowed).
  - W_B holds bready=1 until bvalid.
- **Acceptance (addr_ok is combinational, never high without its req):**
  - Data load: data_req & ~data_wr & R_IDLE & W_IDLE. Loads never pass an in-flight store.
  - Data store: data_req & data_wr & R_IDLE & W_IDLE.
  - Fetch: inst_req & R_IDLE & W_IDLE & ~(data_req & ~data_wr).
  - Arbitration: a data load beats a fetch in the same cycle; a store does not block a fetch.
  - A simultaneous fetch and store are both accepted in the same cycle (one AR, one AW/W).
- **Capture and issue timing:**
  - On acceptance, address/size/wstrb/wdata are registered, along with a read-owner bit (0=inst, 1=data).
  - AR or AW/W is asserted the cycle after addr_ok.
- **Read response:**
  - On rvalid&rready, rdata is registered into rsp_rdata.
  - Next cycle, the owner's *_data_ok pulses for exactly 1 cycle while rsp_rdata holds the value.
  - Minimum latency addr_ok -> data_ok is 3 cycles (arready and rvalid each at first opportunity).
- **Write response:**
  - data_data_ok pulses 1 cycle after bvalid&bready.
  - If a load response and a store response would pulse data_data_ok in the same cycle, the store pulse is delayed 1 cycle. This case is unreachable under the acceptance rules but must be safe.
- **Ordering and R/B interplay:**
  - Responses return in request order per port.
  - rvalid arriving outside R_R, or bvalid outside W_B, is ignored (rready/bready are 0).
- **Reset mid-transaction:** all transactions are dropped; no data_ok pulse follows reset deassertion.

Test Plan:
1. **Single fetch.**
   - Stimulus: inst_req=1, inst_addr=0x1c000000; arready=1; rvalid 2 cycles after AR with rdata=0x02800c0c.
   - Required: inst_addr_ok 1 cycle; arvalid next cycle with araddr=0x1c000000, arsize=2; inst_data_ok one pulse with rsp_rdata=0x02800c0c; data_data_ok stays 0.
2. **Load beats fetch.**
   - Stimulus: same-cycle inst_req (0x1c000004) and data load (0x00001000, size 2).
   - Required: only data_addr_ok=1; first araddr=0x00001000; fetch accepted only after data_data_ok.
3. **Byte store.**
   - Stimulus: data_wr=1, size=0, addr=0x00002003, wstrb=4'b1000, wdata=0xAB000000; awready 3 cycles after wready.
   - Required: wvalid drops after its handshake while awvalid holds; data_data_ok exactly 1 cycle after bvalid; awsize=0.
4. **Store then load, same address.**
   - Stimulus: store accepted, then a load to the same address.
   - Required: load addr_ok stays 0 until W_IDLE; the load's AR is issued only after the B handshake.
5. **Async reset mid-read.**
   - Stimulus: assert reset while in R_R (between clock edges).
   - Required: rready, arvalid and all *_data_ok drop immediately; no pulse after release; first request after release is accepted normally.
6. **Fetch and store in parallel.**
   - Stimulus: simultaneous inst_req and store.
   - Required: both addr_ok=1 in the same cycle; AR and AW/W overlap; both data_ok pulses occur, each exactly once.

Source files
------------

// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module : cpu_axi_bridge
// Brief  : Fetch and data SRAM-like ports merged onto one AXI3 master,
//          at most one read and one write in flight.
// Rev    : 1.0
// ============================================================================
module cpu_axi_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rsp_rdata,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_B    = 2'd2
  } wr_state_t;

  localparam logic [2:0] c_WORD_SIZE = 3'd2;

  rd_state_t   r_rd_state, w_rd_state_nxt;
  wr_state_t   r_wr_state, w_wr_state_nxt;

  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic        r_rd_owner;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_rsp_rdata;
  logic        r_inst_ok;
  logic        r_data_rd_ok;
  logic        r_data_wr_ok;
  logic        r_b_defer;

  logic w_both_idle;
  logic w_load_acc;
  logic w_store_acc;
  logic w_inst_acc;
  logic w_rd_acc;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_wr_want;
  logic w_wr_clash;

  // Loads wait for both channels idle so they can never overtake a store.
  assign w_both_idle = (r_rd_state == R_IDLE) && (r_wr_state == W_IDLE);
  assign w_load_acc  = data_req & ~data_wr & w_both_idle;
  assign w_store_acc = data_req &  data_wr & w_both_idle;
  assign w_inst_acc  = inst_req & w_both_idle & ~(data_req & ~data_wr);
  assign w_rd_acc    = w_load_acc | w_inst_acc;

  assign inst_addr_ok = w_inst_acc;
  assign data_addr_ok = w_load_acc | w_store_acc;

  // Handshakes decoded from state so no path loops back through the valids.
  assign w_ar_hs = (r_rd_state == R_AR) & arready;
  assign w_r_hs  = (r_rd_state == R_R)  & rvalid;
  assign w_aw_hs = (r_wr_state == W_AW) & ~r_aw_done & awready;
  assign w_w_hs  = (r_wr_state == W_AW) & ~r_w_done  & wready;
  assign w_b_hs  = (r_wr_state == W_B)  & bvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
      r_wr_state <= W_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    arvalid        = 1'b0;
    rready         = 1'b0;
    case (r_rd_state)
      R_IDLE: if (w_rd_acc) w_rd_state_nxt = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) w_rd_state_nxt = R_R;
      end
      R_R: begin
        rready = 1'b1;
        if (rvalid) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    awvalid        = 1'b0;
    wvalid         = 1'b0;
    bready         = 1'b0;
    case (r_wr_state)
      W_IDLE: if (w_store_acc) w_wr_state_nxt = W_AW;
      W_AW: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
        if ((r_aw_done | (~r_aw_done & awready)) && (r_w_done | (~r_w_done & wready)))
          w_wr_state_nxt = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_araddr   <= 32'd0;
      r_arsize   <= 3'd0;
      r_rd_owner <= 1'b0;
      r_awaddr   <= 32'd0;
      r_awsize   <= 3'd0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      if (w_rd_acc) begin
        r_araddr   <= w_load_acc ? data_addr : inst_addr;
        r_arsize   <= w_load_acc ? {1'b0, data_size} : c_WORD_SIZE;
        r_rd_owner <= w_load_acc;
      end
      if (w_store_acc) begin
        r_awaddr  <= data_addr;
        r_awsize  <= {1'b0, data_size};
        r_wdata   <= data_wdata;
        r_wstrb   <= data_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

  // A store completion colliding with a load completion slips one cycle.
  assign w_wr_want  = w_b_hs | r_b_defer;
  assign w_wr_clash = w_r_hs & r_rd_owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_rdata  <= 32'd0;
      r_inst_ok    <= 1'b0;
      r_data_rd_ok <= 1'b0;
      r_data_wr_ok <= 1'b0;
      r_b_defer    <= 1'b0;
    end else begin
      if (w_r_hs) r_rsp_rdata <= rdata;
      r_inst_ok    <= w_r_hs & ~r_rd_owner;
      r_data_rd_ok <= w_r_hs &  r_rd_owner;
      r_data_wr_ok <= w_wr_want & ~w_wr_clash;
      r_b_defer    <= w_wr_want &  w_wr_clash;
    end
  end

  assign inst_data_ok = r_inst_ok;
  assign data_data_ok = r_data_rd_ok | r_data_wr_ok;
  assign rsp_rdata    = r_rsp_rdata;
  assign araddr       = r_araddr;
  assign arsize       = r_arsize;
  assign awaddr       = r_awaddr;
  assign awsize       = r_awsize;
  assign wdata        = r_wdata;
  assign wstrb        = r_wstrb;

endmodule
`default_nettype wire
